// File: rtl/mem_region_router_if.sv
// Request, IM, DM and fault signals of the memory region router.
// The router itself connects through the slave modport.
interface mem_region_router_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int FCNT_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_wr;
   logic [DATA_W-1:0] req_wdata;

   logic              im_valid;
   logic              im_ready;
   logic [ADDR_W-1:0] im_addr;

   logic              dm_valid;
   logic              dm_ready;
   logic [ADDR_W-1:0] dm_addr;
   logic              dm_wr;
   logic [DATA_W-1:0] dm_wdata;

   logic              fault_valid;
   logic [1:0]        fault_code;
   logic [ADDR_W-1:0] fault_addr;
   logic [FCNT_W-1:0] fault_count;

   modport slave (
      input  req_valid, req_addr, req_wr, req_wdata, im_ready, dm_ready,
      output req_ready, im_valid, im_addr, dm_valid, dm_addr, dm_wr, dm_wdata,
      output fault_valid, fault_code, fault_addr, fault_count
   );

   modport master (
      output req_valid, req_addr, req_wr, req_wdata, im_ready, dm_ready,
      input  req_ready, im_valid, im_addr, dm_valid, dm_addr, dm_wr, dm_wdata,
      input  fault_valid, fault_code, fault_addr, fault_count
   );
endinterface

// File: rtl/mem_region_router.sv
// Classifies memory requests against the IM/DM map, rebases them to region offsets and
// forwards them through a one-deep registered stage; bad requests become fault pulses.
module mem_region_router #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int FCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              continue_val,
   input  logic [ADDR_W-1:0] im_bottom,
   input  logic [ADDR_W-1:0] im_top,
   input  logic [ADDR_W-1:0] dm_bottom,
   input  logic [ADDR_W-1:0] dm_top,
   mem_region_router_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SEND_IM, SEND_DM} state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_UNMAPPED = 2'b01;
   localparam logic [1:0] FC_IM_WRITE = 2'b10;
   localparam logic [1:0] FC_MISALIGN = 2'b11;

   function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
      return (&v) ? v : v + FCNT_W'(1);
   endfunction

   state_t            state_p1;
   logic              im_valid_p1;
   logic [ADDR_W-1:0] im_addr_p1;
   logic              dm_valid_p1;
   logic [ADDR_W-1:0] dm_addr_p1;
   logic              dm_wr_p1;
   logic [DATA_W-1:0] dm_wdata_p1;
   logic              fault_valid_p1;
   logic [1:0]        fault_code_p1;
   logic [ADDR_W-1:0] fault_addr_p1;
   logic [FCNT_W-1:0] fault_count_p1;

   logic   drain_ok;
   logic   accept;
   logic   misaligned;
   logic   in_im;
   logic   in_dm;
   state_t target_p0;
   logic [1:0] fcode_p0;

   // Stage p0: accept decision and classification of the incoming request
   assign drain_ok = (state_p1 == IDLE)
                   | ((state_p1 == SEND_IM) & bus.im_ready)
                   | ((state_p1 == SEND_DM) & bus.dm_ready);
   assign bus.req_ready = continue_val & drain_ok;
   assign accept        = bus.req_valid & bus.req_ready;

   assign misaligned = (bus.req_addr[2:0] != 3'b000);
   assign in_im      = (bus.req_addr >= im_bottom) && (bus.req_addr <= im_top);
   assign in_dm      = (bus.req_addr >= dm_bottom) && (bus.req_addr <= dm_top);

   // Priority: alignment first, then IM (wins on overlap), then DM.
   always_comb begin
      target_p0 = IDLE;
      fcode_p0  = FC_NONE;
      if (misaligned) begin
         fcode_p0 = FC_MISALIGN;
      end else if (in_im) begin
         if (bus.req_wr) fcode_p0  = FC_IM_WRITE;
         else            target_p0 = SEND_IM;
      end else if (in_dm) begin
         target_p0 = SEND_DM;
      end else begin
         fcode_p0 = FC_UNMAPPED;
      end
   end

   // Stage p1: registered output stage and fault reporting
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p1       <= IDLE;
         im_valid_p1    <= 1'b0;
         im_addr_p1     <= '0;
         dm_valid_p1    <= 1'b0;
         dm_addr_p1     <= '0;
         dm_wr_p1       <= 1'b0;
         dm_wdata_p1    <= '0;
         fault_valid_p1 <= 1'b0;
         fault_code_p1  <= FC_NONE;
         fault_addr_p1  <= '0;
         fault_count_p1 <= '0;
      end else begin
         fault_valid_p1 <= 1'b0;
         if (drain_ok && state_p1 != IDLE) begin
            state_p1    <= IDLE;
            im_valid_p1 <= 1'b0;
            dm_valid_p1 <= 1'b0;
         end
         if (accept) begin
            if (fcode_p0 != FC_NONE) begin
               fault_valid_p1 <= 1'b1;
               fault_code_p1  <= fcode_p0;
               fault_addr_p1  <= bus.req_addr;
               fault_count_p1 <= sat_inc(fault_count_p1);
            end
            case (target_p0)
               SEND_IM: begin
                  state_p1    <= SEND_IM;
                  im_valid_p1 <= 1'b1;
                  im_addr_p1  <= bus.req_addr - im_bottom;
               end
               SEND_DM: begin
                  state_p1    <= SEND_DM;
                  dm_valid_p1 <= 1'b1;
                  dm_addr_p1  <= bus.req_addr - dm_bottom;
                  dm_wr_p1    <= bus.req_wr;
                  dm_wdata_p1 <= bus.req_wdata;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.im_valid    = im_valid_p1;
   assign bus.im_addr     = im_addr_p1;
   assign bus.dm_valid    = dm_valid_p1;
   assign bus.dm_addr     = dm_addr_p1;
   assign bus.dm_wr       = dm_wr_p1;
   assign bus.dm_wdata    = dm_wdata_p1;
   assign bus.fault_valid = fault_valid_p1;
   assign bus.fault_code  = fault_code_p1;
   assign bus.fault_addr  = fault_addr_p1;
   assign bus.fault_count = fault_count_p1;

endmodule

// File: tb/tb_mem_region_router.sv
// Bench for mem_region_router: vector table, directed multi-cycle sequences and a
// randomized run scored against a transaction-level model.
module tb_mem_region_router;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int FCNT_W = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        continue_val;
   logic [63:0] im_bottom, im_top, dm_bottom, dm_top;

   mem_region_router_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FCNT_W(FCNT_W)) bus ();

   mem_region_router #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FCNT_W(FCNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .continue_val (continue_val),
      .im_bottom    (im_bottom),
      .im_top       (im_top),
      .dm_bottom    (dm_bottom),
      .dm_top       (dm_top),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic        wr;
      logic [63:0] wdata;
      int          kind;   // 0 IM, 1 DM, 2 fault
      logic [63:0] off;
      logic [1:0]  code;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      logic        wr;
      logic [63:0] data;
   } xfer_t;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat_cnt(input int v);
      return (v >= (1 << FCNT_W) - 1) ? v : v + 1;
   endfunction

   task automatic drive_req(input logic [63:0] a, input logic w, input logic [63:0] d);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_wr    = w;
      bus.req_wdata = d;
   endtask

   task automatic default_map();
      im_bottom = 64'h0;
      im_top    = 64'h0_FFFF_FFFF;
      dm_bottom = 64'h8_0000_0000;
      dm_top    = 64'hF_FFFF_FFFF;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      drive_req(v.addr, v.wr, v.wdata);
      #1 chk($sformatf("vec%0d_req_ready", idx), bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      chk($sformatf("vec%0d_im_valid", idx), bus.im_valid, v.kind == 0);
      chk($sformatf("vec%0d_dm_valid", idx), bus.dm_valid, v.kind == 1);
      chk($sformatf("vec%0d_fault_valid", idx), bus.fault_valid, v.kind == 2);
      if (v.kind == 0) chk($sformatf("vec%0d_im_addr", idx), bus.im_addr, v.off);
      if (v.kind == 1) begin
         chk($sformatf("vec%0d_dm_addr", idx), bus.dm_addr, v.off);
         chk($sformatf("vec%0d_dm_wr", idx), bus.dm_wr, v.wr);
         chk($sformatf("vec%0d_dm_wdata", idx), bus.dm_wdata, v.wdata);
      end
      if (v.kind == 2) begin
         exp_cnt = sat_cnt(exp_cnt);
         chk($sformatf("vec%0d_fault_code", idx), bus.fault_code, v.code);
         chk($sformatf("vec%0d_fault_addr", idx), bus.fault_addr, v.addr);
      end
      chk($sformatf("vec%0d_fault_count", idx), bus.fault_count, exp_cnt);
      tick();
      chk($sformatf("vec%0d_idle_after", idx),
          {bus.im_valid, bus.dm_valid, bus.fault_valid}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[12];
      xfer_t       imq[$];
      xfer_t       dmq[$];
      xfer_t       x;
      logic        fpend, hold_im, hold_dm, exp_rdy;
      logic [1:0]  fcode_e;
      logic [63:0] faddr_e, hold_im_addr, hold_dm_addr, ra;
      logic [63:0] b2b[4];

      vt[0]  = '{64'h0000_1000,     1'b0, 64'h0,    0, 64'h1000,          2'b00};
      vt[1]  = '{64'h8_0000_0040,   1'b1, 64'hDEAD, 1, 64'h40,            2'b00};
      vt[2]  = '{64'h10_0000_0000,  1'b0, 64'h0,    2, 64'h0,             2'b01};
      vt[3]  = '{64'h0000_0100,     1'b1, 64'h55,   2, 64'h0,             2'b10};
      vt[4]  = '{64'h8_0000_0003,   1'b0, 64'h0,    2, 64'h0,             2'b11};
      vt[5]  = '{64'h0,             1'b0, 64'h0,    0, 64'h0,             2'b00};
      vt[6]  = '{64'hFFFF_FFF8,     1'b0, 64'h0,    0, 64'hFFFF_FFF8,     2'b00};
      vt[7]  = '{64'h1_0000_0000,   1'b1, 64'h1,    2, 64'h0,             2'b01};
      vt[8]  = '{64'hF_FFFF_FFF8,   1'b1, 64'hC0DE, 1, 64'h7_FFFF_FFF8,   2'b00};
      vt[9]  = '{64'h7_FFFF_FFF8,   1'b0, 64'h0,    2, 64'h0,             2'b01};
      vt[10] = '{64'h0000_1004,     1'b0, 64'h0,    2, 64'h0,             2'b11};
      vt[11] = '{64'h10_0000_0005,  1'b0, 64'h0,    2, 64'h0,             2'b11};

      reset = 1'b1;
      continue_val = 1'b1;
      default_map();
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_wr    = 1'b0;
      bus.req_wdata = '0;
      bus.im_ready  = 1'b1;
      bus.dm_ready  = 1'b1;
      tick();
      tick();
      chk("rst_valids", {bus.im_valid, bus.dm_valid, bus.fault_valid}, 0);
      chk("rst_fault_code", bus.fault_code, 0);
      chk("rst_fault_addr", bus.fault_addr, 0);
      chk("rst_fault_count", bus.fault_count, 0);
      chk("rst_im_addr", bus.im_addr, 0);
      chk("rst_dm_fields", {bus.dm_addr, bus.dm_wr}, 0);
      chk("rst_dm_wdata", bus.dm_wdata, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) run_vec(vt[i], i);

      // IM read held off by im_ready for three cycles
      bus.im_ready = 1'b0;
      drive_req(64'h1000, 1'b0, 64'h0);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_im_valid", bus.im_valid, 1);
         chk("hold_im_addr", bus.im_addr, 64'h1000);
         chk("hold_req_ready", bus.req_ready, 0);
         tick();
      end
      bus.im_ready = 1'b1;
      #1 chk("hold_release_ready", bus.req_ready, 1);
      tick();
      chk("hold_done", bus.im_valid, 0);

      // Back-to-back alternating IM/DM reads at full throughput
      b2b[0] = 64'h2000; b2b[1] = 64'h8_0000_0100;
      b2b[2] = 64'h3000; b2b[3] = 64'h8_0000_0200;
      for (int i = 0; i < 4; i++) begin
         drive_req(b2b[i], 1'b0, 64'h0);
         #1 chk("b2b_ready", bus.req_ready, 1);
         tick();
         if (i % 2 == 0) begin
            chk("b2b_im_valid", {bus.im_valid, bus.dm_valid}, 2'b10);
            chk("b2b_im_addr", bus.im_addr, b2b[i]);
         end else begin
            chk("b2b_dm_valid", {bus.im_valid, bus.dm_valid}, 2'b01);
            chk("b2b_dm_addr", bus.dm_addr, b2b[i] - 64'h8_0000_0000);
         end
      end
      bus.req_valid = 1'b0;
      tick();
      chk("b2b_drained", {bus.im_valid, bus.dm_valid}, 0);

      // continue_val low while a DM write is pending
      bus.dm_ready = 1'b0;
      drive_req(64'h8_0000_0040, 1'b1, 64'hDEAD);
      tick();
      continue_val = 1'b0;
      drive_req(64'h1000, 1'b0, 64'h0);
      chk("gate_dm_pending", bus.dm_valid, 1);
      #1 chk("gate_ready_blocked", bus.req_ready, 0);
      bus.dm_ready = 1'b1;
      #1 chk("gate_ready_still0", bus.req_ready, 0);
      tick();
      chk("gate_dm_done", {bus.im_valid, bus.dm_valid}, 0);
      tick();
      chk("gate_no_accept", bus.im_valid, 0);
      bus.req_valid = 1'b0;
      continue_val = 1'b1;

      // Fault accepted on the cycle an IM transfer drains
      bus.im_ready = 1'b0;
      drive_req(64'h4000, 1'b0, 64'h0);
      tick();
      drive_req(64'h10_0000_0000, 1'b0, 64'h0);
      #1 chk("drainf_ready0", bus.req_ready, 0);
      bus.im_ready = 1'b1;
      #1 chk("drainf_ready1", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      exp_cnt = sat_cnt(exp_cnt);
      chk("drainf_valids", {bus.im_valid, bus.dm_valid, bus.fault_valid}, 3'b001);
      chk("drainf_code", bus.fault_code, 2'b01);
      chk("drainf_count", bus.fault_count, exp_cnt);
      tick();

      // Fault counter saturation
      drive_req(64'h9, 1'b0, 64'h0);
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_cnt = sat_cnt(exp_cnt);
      end
      bus.req_valid = 1'b0;
      chk("sat_count", bus.fault_count, exp_cnt);
      chk("sat_all_ones", bus.fault_count, (1 << FCNT_W) - 1);
      tick();

      // Reset while an IM transfer is pending
      bus.im_ready = 1'b0;
      drive_req(64'h1000, 1'b0, 64'h0);
      tick();
      bus.req_valid = 1'b0;
      chk("rstmid_pending", bus.im_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cnt = 0;
      chk("rstmid_valids", {bus.im_valid, bus.dm_valid, bus.fault_valid}, 0);
      chk("rstmid_count", bus.fault_count, 0);
      bus.im_ready = 1'b1;
      tick();
      chk("rstmid_no_stale", bus.im_valid, 0);

      // Randomized run on an overlapping map, scored at transaction level
      im_bottom = 64'h2000; im_top = 64'h2FFF;
      dm_bottom = 64'h2800; dm_top = 64'h5FFF;
      fpend = 1'b0; fcode_e = '0; faddr_e = '0;
      hold_im = 1'b0; hold_dm = 1'b0; hold_im_addr = '0; hold_dm_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         if (c < 2800) begin
            ra = 64'($urandom_range(0, 32'h7FFF));
            if ($urandom % 4 != 0) ra[2:0] = 3'b000;
            if ($urandom % 16 == 0) ra = ra + 64'h10_0000_0000;
            bus.req_valid = ($urandom % 4) != 0;
            bus.req_addr  = ra;
            bus.req_wr    = $urandom % 2;
            bus.req_wdata = {$urandom, $urandom};
            continue_val  = ($urandom % 8) != 0;
            bus.im_ready  = $urandom % 2;
            bus.dm_ready  = $urandom % 2;
         end else begin
            bus.req_valid = 1'b0;
            continue_val  = 1'b1;
            bus.im_ready  = 1'b1;
            bus.dm_ready  = 1'b1;
         end
         #1;
         chk("rnd_exclusive", bus.im_valid & bus.dm_valid, 0);
         if (hold_im) begin
            chk("rnd_im_hold", bus.im_valid, 1);
            chk("rnd_im_stable", bus.im_addr, hold_im_addr);
         end
         if (hold_dm) begin
            chk("rnd_dm_hold", bus.dm_valid, 1);
            chk("rnd_dm_stable", bus.dm_addr, hold_dm_addr);
         end
         exp_rdy = continue_val & ((!bus.im_valid & !bus.dm_valid)
                                 | (bus.im_valid & bus.im_ready)
                                 | (bus.dm_valid & bus.dm_ready));
         chk("rnd_req_ready", bus.req_ready, exp_rdy);
         chk("rnd_fault_valid", bus.fault_valid, fpend);
         if (fpend && bus.fault_valid) begin
            chk("rnd_fault_code", bus.fault_code, fcode_e);
            chk("rnd_fault_addr", bus.fault_addr, faddr_e);
         end
         chk("rnd_fault_count", bus.fault_count, exp_cnt);
         if (bus.im_valid && bus.im_ready) begin
            if (imq.size() == 0) chk("rnd_im_unexpected", 1, 0);
            else begin
               x = imq.pop_front();
               chk("rnd_im_addr", bus.im_addr, x.addr);
            end
         end
         if (bus.dm_valid && bus.dm_ready) begin
            if (dmq.size() == 0) chk("rnd_dm_unexpected", 1, 0);
            else begin
               x = dmq.pop_front();
               chk("rnd_dm_addr", bus.dm_addr, x.addr);
               chk("rnd_dm_wr", bus.dm_wr, x.wr);
               chk("rnd_dm_wdata", bus.dm_wdata, x.data);
            end
         end
         fpend = 1'b0;
         if (bus.req_valid && exp_rdy) begin
            ra = bus.req_addr;
            if (ra % 8 != 0) begin
               fpend = 1'b1; fcode_e = 2'b11;
            end else if (ra >= im_bottom && ra <= im_top) begin
               if (bus.req_wr) begin
                  fpend = 1'b1; fcode_e = 2'b10;
               end else imq.push_back('{ra - im_bottom, 1'b0, 64'h0});
            end else if (ra >= dm_bottom && ra <= dm_top) begin
               dmq.push_back('{ra - dm_bottom, bus.req_wr, bus.req_wdata});
            end else begin
               fpend = 1'b1; fcode_e = 2'b01;
            end
            if (fpend) begin
               faddr_e = ra;
               exp_cnt = sat_cnt(exp_cnt);
            end
         end
         hold_im = bus.im_valid & !bus.im_ready;
         hold_dm = bus.dm_valid & !bus.dm_ready;
         hold_im_addr = bus.im_addr;
         hold_dm_addr = bus.dm_addr;
         tick();
      end
      chk("rnd_imq_empty", imq.size(), 0);
      chk("rnd_dmq_empty", dmq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
